// File: rtl/mem_rd_pkg.sv
// mem_rd_pkg: shared state encoding and default sizes for the burst reader
package mem_rd_pkg;
    localparam int ADDR_W_DEF = 10;
    localparam int DATA_W_DEF = 16;
    localparam int BUF_DEPTH  = 2;
    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DRAIN = 2'd2} state_t;
endpackage

// File: rtl/rd_skid_fifo.sv
// rd_skid_fifo: 2-entry buffer of read words plus last tag, head gated to zero when empty
module rd_skid_fifo import mem_rd_pkg::*; #(
    parameter int W = DATA_W_DEF + 1
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic [W-1:0] head,
    output logic [1:0]   count
);
    logic [W-1:0] mem [BUF_DEPTH];
    logic rd_ptr, wr_ptr;
    always_ff @(posedge i_clk)
        if (push) mem[wr_ptr] <= push_data;
    always_ff @(posedge i_clk)
        if (!i_rst_n) begin
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            wr_ptr <= wr_ptr ^ push;
            rd_ptr <= rd_ptr ^ pop;
            count  <= count + {1'b0, push} - {1'b0, pop};
        end
    assign head = (count != 2'd0) ? mem[rd_ptr] : '0;
endmodule

// File: rtl/mem_burst_reader.sv
// mem_burst_reader: streams a contiguous RAM burst out through a 2-entry valid/ready buffer
module mem_burst_reader import mem_rd_pkg::*; #(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_start,
    input  logic [ADDR_W-1:0] i_base_addr,
    input  logic [ADDR_W:0]   i_len,
    output logic              o_busy,
    output logic              o_done,
    output logic [ADDR_W-1:0] o_r_addr,
    input  logic [DATA_W-1:0] i_r_data,
    output logic [DATA_W-1:0] o_m_data,
    output logic              o_m_valid,
    output logic              o_m_last,
    input  logic              i_m_ready
);
    localparam logic [ADDR_W:0]   LEN_ONE  = 1;
    localparam logic [ADDR_W-1:0] ADDR_ONE = 1;
    state_t state, state_nx;
    logic [ADDR_W:0] remaining;
    logic inflight, inflight_last, pop, credit, issue, go, fin;
    logic [1:0] count;
    always_comb begin
        pop      = o_m_valid & i_m_ready;
        // a slot freed by this cycle's pop can be reused by this cycle's issue
        credit   = {1'b0, count} + {2'b0, inflight} < 3'd2 + {2'b0, pop};
        issue    = state == RUN && remaining != '0 && credit;
        go       = state == IDLE && i_start && i_len != '0;
        fin      = state == DRAIN && pop && o_m_last;
        state_nx = go ? RUN : (issue && remaining == LEN_ONE) ? DRAIN : fin ? IDLE : state;
    end
    always_ff @(posedge i_clk)
        if (!i_rst_n) begin
            state         <= IDLE;
            o_r_addr      <= '0;
            remaining     <= '0;
            inflight      <= 1'b0;
            inflight_last <= 1'b0;
            o_done        <= 1'b0;
        end else begin
            state         <= state_nx;
            inflight      <= issue;
            inflight_last <= issue && remaining == LEN_ONE;
            o_done        <= fin || (state == IDLE && i_start && i_len == '0);
            if (go) begin
                o_r_addr  <= i_base_addr;
                remaining <= i_len;
            end else if (issue) begin
                o_r_addr  <= o_r_addr + ADDR_ONE;
                remaining <= remaining - LEN_ONE;
            end
        end
    assign o_busy    = state != IDLE;
    assign o_m_valid = count != 2'd0;
    rd_skid_fifo #(.W(DATA_W + 1)) u_fifo (
        .i_clk     (i_clk),
        .i_rst_n   (i_rst_n),
        .push      (inflight),
        .push_data ({inflight_last, i_r_data}),
        .pop       (pop),
        .head      ({o_m_last, o_m_data}),
        .count     (count)
    );
endmodule

// File: tb/tb_mem_burst_reader.sv
// tb_mem_burst_reader: randomized bursts checked against a queue model of the expected beat stream
module tb_mem_burst_reader;
    logic        i_clk = 0, i_rst_n = 0, i_start = 0, i_m_ready = 1;
    logic [9:0]  i_base_addr = 0, o_r_addr;
    logic [10:0] i_len = 0;
    logic [15:0] i_r_data, o_m_data;
    logic        o_busy, o_done, o_m_valid, o_m_last;
    logic [15:0] mem [1024];
    int vectors = 0, miscompares = 0, cyc = 0, acc_cyc = 0, zacc_cyc = 0, done_cyc = 0;
    int mode = 0, pat_i = 0;
    logic pat [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    logic [15:0] exp_d[$], seen_d[$];
    logic        exp_l[$], seen_l[$];
    int          seen_c[$];
    logic exp_busy = 0, exp_done = 0, was_rst = 0, hold = 0, hold_l = 0, first_pend = 0, fin, el, acc;
    logic [15:0] hold_d = 0, ed;
    logic [15:0] wrap_exp [4] = '{16'hA3FE, 16'hA3FF, 16'hA000, 16'hA001};

    mem_burst_reader dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_start(i_start), .i_base_addr(i_base_addr),
        .i_len(i_len), .o_busy(o_busy), .o_done(o_done), .o_r_addr(o_r_addr),
        .i_r_data(i_r_data), .o_m_data(o_m_data), .o_m_valid(o_m_valid),
        .o_m_last(o_m_last), .i_m_ready(i_m_ready)
    );

    always #5 i_clk = ~i_clk;
    always @(posedge i_clk) i_r_data <= mem[o_r_addr];

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    initial forever begin
        @(posedge i_clk);
        #1;
        if (mode == 0) i_m_ready = 1'b1;
        else if (mode == 1) begin
            i_m_ready = pat[pat_i % 6];
            pat_i++;
        end else i_m_ready = 1'($urandom_range(0, 1));
    end

    always @(negedge i_clk) begin
        cyc++;
        if (was_rst) begin
            chk("rst_r_addr", 32'(o_r_addr), 0);
            chk("rst_m_valid", 32'(o_m_valid), 0);
            chk("rst_m_last", 32'(o_m_last), 0);
            chk("rst_m_data", 32'(o_m_data), 0);
        end
        was_rst = !i_rst_n;
        chk("busy", 32'(o_busy), 32'(exp_busy));
        chk("done", 32'(o_done), 32'(exp_done));
        chk("count_le_2", 32'(dut.count <= 2'd2), 1);
        if (o_done) done_cyc = cyc;
        if (!i_rst_n) begin
            exp_d.delete();
            exp_l.delete();
            exp_busy = 0; exp_done = 0; hold = 0; first_pend = 0;
        end else begin
            if (hold) begin
                chk("stall_valid", 32'(o_m_valid), 1);
                chk("stall_data", 32'(o_m_data), 32'(hold_d));
                chk("stall_last", 32'(o_m_last), 32'(hold_l));
            end
            if (o_m_valid) chk("beat_expected", 32'(exp_d.size() != 0), 1);
            if (first_pend && o_m_valid) begin
                chk("first_latency", cyc - acc_cyc, 3);
                first_pend = 0;
            end
            fin = 0;
            if (o_m_valid && i_m_ready && exp_d.size() != 0) begin
                ed = exp_d.pop_front();
                el = exp_l.pop_front();
                chk("beat_data", 32'(o_m_data), 32'(ed));
                chk("beat_last", 32'(o_m_last), 32'(el));
                seen_d.push_back(o_m_data);
                seen_l.push_back(o_m_last);
                seen_c.push_back(cyc);
                fin = el;
            end
            hold = o_m_valid && !i_m_ready;
            hold_d = o_m_data;
            hold_l = o_m_last;
            acc = i_start && !exp_busy;
            if (acc && i_len != 0) begin
                acc_cyc = cyc;
                first_pend = 1;
                for (int k = 0; k < int'(i_len); k++) begin
                    exp_d.push_back(mem[(int'(i_base_addr) + k) % 1024]);
                    exp_l.push_back(k == int'(i_len) - 1);
                end
            end
            if (acc && i_len == 0) zacc_cyc = cyc;
            exp_done = fin || (acc && i_len == 0);
            exp_busy = (exp_busy && !fin) || (acc && i_len != 0);
        end
    end

    task automatic start(input int base, input int len);
        @(posedge i_clk);
        #1;
        i_start = 1;
        i_base_addr = 10'(base);
        i_len = 11'(len);
        @(posedge i_clk);
        #1;
        i_start = 0;
    endtask

    task automatic wait_done(input int budget);
        logic got = 0;
        for (int n = 0; n < budget && !got; n++) begin
            @(negedge i_clk);
            #1;
            got = o_done;
        end
        chk("done_timeout", 32'(got), 1);
    endtask

    initial begin
        int n0;
        for (int k = 0; k < 1024; k++) mem[k] = 16'hA000 + 16'(k);
        repeat (3) @(posedge i_clk);
        #1 i_rst_n = 1;

        // basic burst, ready held high
        n0 = seen_d.size();
        start(5, 4);
        wait_done(50);
        chk("basic_count", seen_d.size() - n0, 4);
        for (int i = 0; i < 4; i++) begin
            chk("basic_data", 32'(seen_d[n0 + i]), 32'h0000A005 + i);
            chk("basic_last", 32'(seen_l[n0 + i]), 32'(i == 3));
            chk("basic_no_bubble", seen_c[n0 + i] - seen_c[n0], i);
        end
        chk("basic_first_latency", seen_c[n0] - acc_cyc, 3);
        chk("basic_done_timing", done_cyc - seen_c[n0 + 3], 1);

        // same burst under a fixed backpressure pattern
        mode = 1; pat_i = 0;
        n0 = seen_d.size();
        start(5, 4);
        wait_done(100);
        chk("bp_count", seen_d.size() - n0, 4);
        for (int i = 0; i < 4; i++) chk("bp_data", 32'(seen_d[n0 + i]), 32'h0000A005 + i);

        // wrap-around with random ready
        mode = 2;
        n0 = seen_d.size();
        start(1022, 4);
        wait_done(100);
        chk("wrap_count", seen_d.size() - n0, 4);
        for (int i = 0; i < 4; i++) chk("wrap_data", 32'(seen_d[n0 + i]), 32'(wrap_exp[i]));

        // full address space
        mode = 0;
        n0 = seen_d.size();
        start(0, 1024);
        wait_done(1200);
        chk("full_count", seen_d.size() - n0, 1024);
        chk("full_first", 32'(seen_d[n0]), 32'h0000A000);
        chk("full_final", 32'(seen_d[n0 + 1023]), 32'h0000A3FF);
        chk("full_final_last", 32'(seen_l[n0 + 1023]), 1);
        chk("full_prev_last", 32'(seen_l[n0 + 1022]), 0);

        // zero length
        n0 = seen_d.size();
        start(0, 0);
        wait_done(10);
        chk("zero_done_timing", done_cyc - zacc_cyc, 1);
        repeat (3) @(negedge i_clk);
        chk("zero_no_beats", seen_d.size() - n0, 0);

        // start while busy is ignored
        mode = 2;
        n0 = seen_d.size();
        start(200, 6);
        repeat (2) @(posedge i_clk);
        start(300, 5);
        wait_done(200);
        repeat (4) @(negedge i_clk);
        chk("ignore_count", seen_d.size() - n0, 6);
        chk("ignore_first", 32'(seen_d[n0]), 32'h0000A0C8);
        chk("ignore_final", 32'(seen_d[n0 + 5]), 32'h0000A0CD);

        // random bursts over random memory contents
        for (int k = 0; k < 1024; k++) mem[k] = 16'($urandom);
        for (int b = 0; b < 25; b++) begin
            mode = $urandom_range(0, 2);
            start($urandom_range(0, 1023), ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 40));
            wait_done(400);
        end

        // reset after 2 of 6 beats, then a fresh burst
        for (int k = 0; k < 1024; k++) mem[k] = 16'hA000 + 16'(k);
        mode = 0;
        n0 = seen_d.size();
        start(10, 6);
        for (int n = 0; n < 50 && seen_d.size() < n0 + 2; n++) @(posedge i_clk);
        #1 i_rst_n = 0;
        @(posedge i_clk);
        #1 i_rst_n = 1;
        @(negedge i_clk);
        #1;
        chk("rst_beats_before", seen_d.size() - n0, 2);
        n0 = seen_d.size();
        start(100, 3);
        wait_done(50);
        chk("post_rst_count", seen_d.size() - n0, 3);
        for (int i = 0; i < 3; i++) chk("post_rst_data", 32'(seen_d[n0 + i]), 32'h0000A064 + i);
        chk("post_rst_last", 32'(seen_l[n0 + 2]), 1);
        repeat (3) @(negedge i_clk);
        chk("model_queue_empty", exp_d.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/mem_burst_reader.md
# mem_burst_reader

Reads a contiguous burst of words out of the team's simple dual-port block RAM through its read port, and delivers them as a valid/ready stream. A 2-entry output buffer absorbs the RAM's one-cycle registered read latency and downstream backpressure. The block is the read-side counterpart of the write-port users. It sits between the RAM's read address/data pins and any stream consumer such as a UART TX or a DSP datapath.

## Interface
- ADDR_W, 10, RAM address width; the burst address wraps modulo 2^ADDR_W
- DATA_W, 16, RAM word width
- i_clk  in  1  single clock; all logic is on the rising edge
- i_rst_n  in  1  reset, synchronous, active-low
- i_start  in  1  start request; sampled only while idle
- i_base_addr  in  ADDR_W  first word address; sampled with i_start
- i_len  in  ADDR_W+1  number of words, 0..2^ADDR_W; sampled with i_start
- o_busy  out  1  burst in progress
- o_done  out  1  one-cycle pulse after the final beat, or after a zero-length start
- o_r_addr  out  ADDR_W  registered read address to the RAM
- i_r_data  in  DATA_W  RAM read data; corresponds to the o_r_addr of the previous cycle
- o_m_data  out  DATA_W  stream data
- o_m_valid  out  1  stream valid
- o_m_last  out  1  marks the final beat of the burst; qualified by o_m_valid
- i_m_ready  in  1  stream ready

## Operation
- **States:** IDLE, RUN, DRAIN.
- **IDLE:**
  - i_start=1 with i_len>0 latches the base address and length, loads o_r_addr=i_base_addr and remaining=i_len, and moves to RUN.
  - i_start=1 with i_len=0 stays in IDLE and pulses o_done on the next cycle.
- **RUN:** a read is "issued" in any cycle where remaining>0 and buffer credit exists.
  - Issue marks the current o_r_addr as in-flight, increments o_r_addr (wrapping 2^ADDR_W-1 → 0) and decrements remaining.
  - Credit rule: count + inflight − (o_m_valid & i_m_ready) < 2.
  - An in-flight read lands in the buffer on the next cycle, tagged last if it was the final issued word.
  - When remaining reaches 0, the state moves to DRAIN.
- **DRAIN:** wait until the buffer is empty and nothing is in flight, then return to IDLE.
- **Done/busy timing:** o_done is asserted on the edge following the last-beat handshake, and o_busy is deasserted on that same edge.
- **Stream behaviour:**
  - o_m_data/o_m_valid always present the buffer head.
  - Data is held stable while o_m_valid=1 and i_m_ready=0.
  - Exactly i_len beats are delivered per burst, in address order, with o_m_last=1 only on beat i_len.
- i_start while busy is ignored, with no effect on the burst in flight.
- o_r_addr holds its value when not issuing. The RAM reads every cycle, so only issue-tagged returns are captured.
- **Reset (any state, including mid-burst):**
  - state → IDLE, buffer and in-flight flag cleared.
  - o_r_addr=0, o_busy=0, o_done=0, o_m_valid=0, o_m_last=0, o_m_data=0.

## Timing
- **Start at edge E0:**
  - o_r_addr=base and o_busy=1 after E0.
  - First issue during cycle E0–E1; RAM data valid after E1.
  - Captured at E2; o_m_valid=1 after E2.
  - Start-to-first-beat latency is 2 cycles.
- With i_m_ready held high, throughput is 1 beat/cycle with no bubbles. The burst finishes at E(1+i_len), and o_done rises at the following edge.
- Backpressure stalls issue within the same cycle via the credit rule. The buffer never overflows: count ≤ 2.
- Wrap-around is transparent: base=1022, len=4 reads 1022, 1023, 0, 1.
- len=2^ADDR_W reads every word exactly once. remaining and i_len are ADDR_W+1 bits wide.

## Structure
- **Package mem_rd_pkg:**
  - state encodings IDLE=2'd0, RUN=2'd1, DRAIN=2'd2
  - default ADDR_W/DATA_W constants
  - buffer depth constant = 2
- **Sub-module rd_skid_fifo:**
  - 2-entry, DATA_W+1 wide (data plus last tag)
  - push/pop with simultaneous push and pop allowed when full
  - exposes count
- The FSM, address counter and credit logic stay in the top-level module.

## Test plan
- **Basic burst:** RAM preloaded mem[k]=k+16'hA000; start base=5, len=4, ready=1 → beats A005..A008 on consecutive cycles, last on A008, first valid 2 cycles after start, o_done 1 cycle after last.
- **Backpressure:** same burst with ready toggling 1,0,0,1,0,1… → identical data order, no duplicates or drops, data stable while stalled, count never exceeds 2.
- **Wrap and full length:** base=1022, len=4 → addresses 1022, 1023, 0, 1. base=0, len=1024 → 1024 beats, last on mem[1023].
- **Zero length and ignored start:** len=0 → o_done pulse next cycle, no valid, o_busy stays 0. A second i_start mid-burst → no change to the active burst.
- **Reset mid-burst:** assert i_rst_n=0 for 1 cycle after 2 of 6 beats → all outputs 0 next cycle. A new start of base=100, len=3 then delivers mem[100..102] correctly.
